lut_builder: RTL and testbench
==============================

// Module: lut_builder
// PURPOSE
// Runtime generator for the control-bounded filter's coefficient lookup tables: accepts SIZE
//   complex coefficients c[j] and writes all 2**SIZE entries E[i] = sum_j (i[j] ? +c[j] : -c[j])
//   into the LUT storage write port.
// Replaces elaboration-time table generation, so filter coefficients can be reprogrammed.
// Sits between the coefficient configuration interface and the LUT memories.
// PARAMETERS
// SIZE  4   control bits per LUT select word; the table has 2**SIZE entries
// DW    16  signed two's-complement width of each coefficient component (re, im)
// OW    DW+$clog2(SIZE)+1 (localparam)  signed width of each table entry component
// PORTS
// clk         in   1     clock, all logic on rising edge
// rstn        in   1     asynchronous active-low reset
// start       in   1     single-cycle request to begin a new load/build; ignored while busy=1
// coef_valid  in   1     coefficient handshake valid
// coef_ready  out  1     coefficient handshake ready
// coef_re     in   DW    coefficient real part, signed
// coef_im     in   DW    coefficient imaginary part, signed
// wr_en       out  1     table write strobe
// wr_addr     out  SIZE  table entry index
// wr_re       out  OW    entry real part, signed
// wr_im       out  OW    entry imaginary part, signed
// busy        out  1     high from the cycle after start is accepted through the done cycle
// done        out  1     one-cycle pulse: table fully written
// BEHAVIOUR
// Reset (async assert, sync release): state=IDLE; coef_ready, wr_en, busy, done=0;
//   wr_addr, wr_re, wr_im=0; coefficient regs, accumulator, counters=0.
// FSM IDLE -> LOAD -> BUILD -> DONE -> IDLE.
//  IDLE : coef_ready=0. start=1 -> LOAD; clear k, acc_re=acc_im=0.
//  LOAD : coef_ready=1. On valid&&ready: c[k]<=coef; acc -= sext(coef); k++.
//         Acceptance of coefficient k=SIZE-1 -> BUILD, g=0. Gaps in coef_valid simply stall.
//  BUILD: one write per cycle, g = 0 .. 2**SIZE-1, in Gray-code order; coef_ready=0.
//         g=0: wr_addr=0, data=acc (= -sum c[j]).
//         g>0: j = trailing-zero count of g; a = g^(g>>1); bit a[j] is the flipped bit;
//         acc += a[j] ? 2*c[j] : -2*c[j]; write wr_addr=a with the updated acc (registered
//         outputs).
//         After g=2**SIZE-1 -> DONE.
//  DONE : done=1 and busy=1 for one cycle; wr_en=0 -> IDLE.
// Timing: last coefficient accepted at edge T -> wr_en=1 on cycles T+1..T+2**SIZE,
//   done on cycle T+2**SIZE+1. Build is exactly 2**SIZE cycles, no stalls, no write backpressure.
// wr_addr/wr_re/wr_im hold their last value when wr_en=0.
// Arithmetic: sign-extend to OW before add/sub. OW is sized so that no overflow is possible:
//   |E| <= SIZE*2**(DW-1). No saturation and no rounding.
// Boundaries:
//  - start while busy=1 (including the DONE cycle) is ignored.
//  - coef_valid in IDLE or BUILD is not accepted (coef_ready=0).
//  - start and coef_valid in the same IDLE cycle: start accepted, coefficient not accepted.
//  - SIZE=1: two writes, addresses 0 then 1.
//  - rstn asserted mid-LOAD or mid-BUILD: immediate return to reset state. The partially
//    written table is invalid until a subsequent run asserts done.
// TESTING
// 1 SIZE=2; c0=(3,-1), c1=(5,2), coef_valid held high -> writes in order
//   addr0=(-8,-1), addr1=(-2,-3), addr3=(8,1), addr2=(2,3); done 5 cycles after 2nd accept.
// 2 SIZE=4, DW=16; all c=(-32768,32767) -> addr0=(131072,-131068), addr15=(-131072,131068);
//   all 16 addresses written exactly once.
// 3 SIZE=4; random coef_valid gaps (0-5 cycles) -> coef_ready high throughout LOAD; table
//   identical to the gap-free run; wr_en never high during LOAD.
// 4 start pulsed during BUILD and in the DONE cycle -> ignored; no second LOAD; busy falls
//   the cycle after done.
// 5 rstn low for 1 cycle at BUILD g=5 -> all outputs 0 within the reset cycle, state IDLE;
//   a new start/load produces a correct full table and done.
// 6 SIZE=3, random coefficients, 100 runs -> every entry matches a reference model computing
//   sum(+/-c[j]) from the address bits.

Source files
------------

// File: rtl/lut_builder.sv
// Runtime builder for control-bounded filter LUTs: loads SIZE complex coefficients, then
// writes every entry E[i] = sum_j (i[j] ? +c[j] : -c[j]) once, walking the table in Gray order.
module lut_builder #(
  parameter int SIZE = 4,
  parameter int DW   = 16,
  localparam int OW  = DW + $clog2(SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  input  logic signed [DW-1:0] coef_re,
  input  logic signed [DW-1:0] coef_im,
  output logic                 wr_en,
  output logic [SIZE-1:0]      wr_addr,
  output logic signed [OW-1:0] wr_re,
  output logic signed [OW-1:0] wr_im,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);
  localparam int KW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CN = 2 ** KW;
  localparam logic [SIZE-1:0] G_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BUILD = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [1:0]           rst_sync;
  logic                 rst_n_i;
  logic                 start_ok;
  logic                 coef_fire;
  logic [KW-1:0]        k;
  logic [SIZE-1:0]      g;
  logic [SIZE-1:0]      gray;
  logic [KW-1:0]        tz;
  logic signed [DW-1:0] c_re [CN];
  logic signed [DW-1:0] c_im [CN];
  logic signed [OW-1:0] acc_re, acc_im;
  logic signed [OW-1:0] acc_re_nxt, acc_im_nxt;
  logic signed [OW-1:0] dbl_re, dbl_im;

  // Reset asserts immediately and releases two clocks after rstn rises.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  // Coefficient handshake: a coefficient transfers on a rising edge where coef_valid and
  // coef_ready are both high; coef_ready is high exactly while in LOAD and never waits on valid.
  assign coef_ready = (state == LOAD);
  assign coef_fire  = coef_valid && coef_ready;
  assign start_ok   = (state == IDLE) && start && !busy;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = LOAD;
      LOAD:    if (coef_fire && (k == KW'(SIZE - 1))) state_next = BUILD;
      BUILD:   if (g == G_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Step g flips bit tz of the Gray address; moving that bit between -c and +c costs 2*c.
  always_comb begin
    gray = g ^ (g >> 1);
    tz   = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (g[i]) tz = KW'(i);
    end
    dbl_re = OW'(c_re[tz]) <<< 1;
    dbl_im = OW'(c_im[tz]) <<< 1;
    if (g == '0) begin
      acc_re_nxt = acc_re;
      acc_im_nxt = acc_im;
    end else if (gray[tz]) begin
      acc_re_nxt = acc_re + dbl_re;
      acc_im_nxt = acc_im + dbl_im;
    end else begin
      acc_re_nxt = acc_re - dbl_re;
      acc_im_nxt = acc_im - dbl_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      k       <= '0;
      g       <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_re   <= '0;
      wr_im   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < CN; i++) begin
        c_re[i] <= '0;
        c_im[i] <= '0;
      end
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            busy   <= 1'b1;
            k      <= '0;
            acc_re <= '0;
            acc_im <= '0;
          end
        end
        LOAD: begin
          // Accumulator ends LOAD holding entry 0, i.e. every coefficient negated.
          if (coef_fire) begin
            c_re[k] <= coef_re;
            c_im[k] <= coef_im;
            acc_re  <= acc_re - OW'(coef_re);
            acc_im  <= acc_im - OW'(coef_im);
            k       <= k + 1'b1;
            g       <= '0;
          end
        end
        BUILD: begin
          wr_en   <= 1'b1;
          wr_addr <= gray;
          wr_re   <= acc_re_nxt;
          wr_im   <= acc_im_nxt;
          acc_re  <= acc_re_nxt;
          acc_im  <= acc_im_nxt;
          g       <= g + 1'b1;
        end
        DONE:    done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_builder.sv
// Bench for lut_builder: four instances (SIZE 1..4) sharing the coefficient bus, driven
// one at a time and checked against an arithmetic model of the table.
module tb_lut_builder;
  localparam int W = 68;

  typedef struct {
    int              size;
    int              gap;
    bit              hold;
    bit              poke;
    bit              sv;
    logic [3:0][15:0] cr;
    logic [3:0][15:0] ci;
    int              e0r, e0i, elr, eli;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic [4:1] start_v;
  logic coef_valid;
  logic signed [15:0] coef_re, coef_im;

  logic rdy1, wen1, busy1, done1; logic [0:0] a1; logic signed [16:0] re1, im1; logic [1:0] st1;
  logic rdy2, wen2, busy2, done2; logic [1:0] a2; logic signed [17:0] re2, im2; logic [1:0] st2;
  logic rdy3, wen3, busy3, done3; logic [2:0] a3; logic signed [18:0] re3, im3; logic [1:0] st3;
  logic rdy4, wen4, busy4, done4; logic [3:0] a4; logic signed [18:0] re4, im4; logic [1:0] st4;

  int sel;
  logic s_ready, s_wen, s_busy, s_done;
  int s_addr, s_re, s_im;
  logic [1:0] s_st;

  int n_cmp = 0;
  int n_err = 0;
  int cre [4];
  int cim [4];
  int got0r, got0i, gotlr, gotli;
  logic [W-1:0] exp_q [$];
  vec_t vt [6];

  always #5 clk = ~clk;

  lut_builder #(.SIZE(1), .DW(16)) u1 (.clk(clk), .rstn(rstn), .start(start_v[1]),
    .coef_valid(coef_valid), .coef_ready(rdy1), .coef_re(coef_re), .coef_im(coef_im),
    .wr_en(wen1), .wr_addr(a1), .wr_re(re1), .wr_im(im1), .busy(busy1), .done(done1),
    .dbg_state(st1));
  lut_builder #(.SIZE(2), .DW(16)) u2 (.clk(clk), .rstn(rstn), .start(start_v[2]),
    .coef_valid(coef_valid), .coef_ready(rdy2), .coef_re(coef_re), .coef_im(coef_im),
    .wr_en(wen2), .wr_addr(a2), .wr_re(re2), .wr_im(im2), .busy(busy2), .done(done2),
    .dbg_state(st2));
  lut_builder #(.SIZE(3), .DW(16)) u3 (.clk(clk), .rstn(rstn), .start(start_v[3]),
    .coef_valid(coef_valid), .coef_ready(rdy3), .coef_re(coef_re), .coef_im(coef_im),
    .wr_en(wen3), .wr_addr(a3), .wr_re(re3), .wr_im(im3), .busy(busy3), .done(done3),
    .dbg_state(st3));
  lut_builder #(.SIZE(4), .DW(16)) u4 (.clk(clk), .rstn(rstn), .start(start_v[4]),
    .coef_valid(coef_valid), .coef_ready(rdy4), .coef_re(coef_re), .coef_im(coef_im),
    .wr_en(wen4), .wr_addr(a4), .wr_re(re4), .wr_im(im4), .busy(busy4), .done(done4),
    .dbg_state(st4));

  always_comb begin
    s_ready = 1'b0; s_wen = 1'b0; s_busy = 1'b0; s_done = 1'b0;
    s_addr = 0; s_re = 0; s_im = 0; s_st = 2'd0;
    case (sel)
      1: begin s_ready = rdy1; s_wen = wen1; s_busy = busy1; s_done = done1;
               s_addr = int'(a1); s_re = int'(re1); s_im = int'(im1); s_st = st1; end
      2: begin s_ready = rdy2; s_wen = wen2; s_busy = busy2; s_done = done2;
               s_addr = int'(a2); s_re = int'(re2); s_im = int'(im2); s_st = st2; end
      3: begin s_ready = rdy3; s_wen = wen3; s_busy = busy3; s_done = done3;
               s_addr = int'(a3); s_re = int'(re3); s_im = int'(im3); s_st = st3; end
      default: begin s_ready = rdy4; s_wen = wen4; s_busy = busy4; s_done = done4;
               s_addr = int'(a4); s_re = int'(re4); s_im = int'(im4); s_st = st4; end
    endcase
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", name, got, exp, sel, $time);
    end
  endtask

  // Entry for address a: +c[j] where bit j of a is set, -c[j] otherwise.
  function automatic int model(input int size, input int a, input bit im);
    int s, c;
    s = 0;
    for (int j = 0; j < size; j++) begin
      c = im ? cim[j] : cre[j];
      s += ((a >> j) & 1) ? c : -c;
    end
    return s;
  endfunction

  function automatic void setc(input int v, input int j, input int re, input int im);
    vt[v].cr[j] = 16'(re);
    vt[v].ci[j] = 16'(im);
  endfunction

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {s_wen, s_busy, s_done, s_ready}, 0);
    chk({name, "_data"}, s_addr | s_re | s_im, 0);
    chk({name, "_state"}, s_st, 0);
  endtask

  task automatic run(input int size, input int max_gap, input bit hold, input bit poke,
                     input bit sv, input int abort_at);
    int n, k, guard, gap, nwr, mask;
    logic [W-1:0] e;
    n = 1 << size;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      int a;
      a = i ^ (i >> 1);
      exp_q.push_back({4'(a), 32'(model(size, a, 1'b0)), 32'(model(size, a, 1'b1))});
    end
    sel = size;
    @(negedge clk);
    start_v[size] = 1'b1;
    if (sv) begin coef_valid = 1'b1; coef_re = 16'sh1234; coef_im = -16'sd77; end
    chk("idle_ready", s_ready, 0);
    @(negedge clk);
    start_v = '0;
    chk("busy_rise", s_busy, 1);
    k = 0; guard = 0;
    while (k < size && guard < 200) begin
      gap = $urandom_range(0, max_gap);
      for (int i = 0; i < gap; i++) begin
        coef_valid = 1'b0;
        chk("load_ctl", {s_ready, s_wen}, 2'b10);
        guard++;
        @(negedge clk);
      end
      coef_valid = 1'b1; coef_re = 16'(cre[k]); coef_im = 16'(cim[k]);
      chk("load_ctl", {s_ready, s_wen}, 2'b10);
      if (s_ready) k++;
      guard++;
      @(negedge clk);
    end
    if (k < size) chk("load_timeout", k, size);
    if (hold) begin coef_re = 16'sh7fff; coef_im = -16'sd32768; end
    else coef_valid = 1'b0;
    chk("ctl_c0", {s_wen, s_done, s_busy, s_ready}, 4'b0010);
    nwr = 0; mask = 0;
    for (int cyc = 1; cyc <= n + 2; cyc++) begin
      @(negedge clk);
      chk("ctl", {s_wen, s_done, s_busy, s_ready},
          (cyc <= n) ? 4'b1010 : (cyc == n + 1) ? 4'b0110 : 4'b0000);
      if (s_wen) begin
        nwr++;
        if (exp_q.size() == 0) chk("extra_wr", nwr, n);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", s_addr, longint'(e[67:64]));
          chk("wr_re", s_re, longint'($signed(e[63:32])));
          chk("wr_im", s_im, longint'($signed(e[31:0])));
          mask |= 1 << s_addr;
          if (s_addr == 0) begin got0r = s_re; got0i = s_im; end
          if (s_addr == n - 1) begin gotlr = s_re; gotli = s_im; end
        end
      end
      if (cyc == abort_at) begin
        rstn = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        rstn = 1'b1;
        coef_valid = 1'b0;
        start_v = '0;
        repeat (4) @(negedge clk);
        return;
      end
      start_v = '0;
      if (poke && (cyc == 3 || cyc == n + 1)) start_v[size] = 1'b1;
    end
    start_v = '0;
    coef_valid = 1'b0;
    chk("nwr", nwr, n);
    chk("mask", mask, (1 << n) - 1);
    @(negedge clk);
    chk("idle_after", {s_busy, s_ready, s_wen}, 3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1; start_v = '0; coef_valid = 1'b0; coef_re = '0; coef_im = '0; sel = 4;
    got0r = 0; got0i = 0; gotlr = 0; gotli = 0;

    vt[0] = '{size: 2, gap: 0, hold: 1, poke: 0, sv: 0, cr: '0, ci: '0,
              e0r: -8, e0i: -1, elr: 8, eli: 1};
    setc(0, 0, 3, -1); setc(0, 1, 5, 2);
    vt[1] = '{size: 4, gap: 0, hold: 0, poke: 1, sv: 1, cr: '0, ci: '0,
              e0r: 131072, e0i: -131068, elr: -131072, eli: 131068};
    for (int j = 0; j < 4; j++) setc(1, j, -32768, 32767);
    vt[2] = '{size: 4, gap: 0, hold: 0, poke: 0, sv: 0, cr: '0, ci: '0,
              e0r: 4245, e0i: -1038, elr: -4245, eli: 1038};
    setc(2, 0, 100, -7); setc(2, 1, -250, 33); setc(2, 2, 1, 1000); setc(2, 3, -4096, 12);
    vt[3] = vt[2];
    vt[3].gap = 5;
    vt[4] = '{size: 1, gap: 1, hold: 0, poke: 0, sv: 0, cr: '0, ci: '0,
              e0r: -7, e0i: 3, elr: 7, eli: -3};
    setc(4, 0, 7, -3);
    vt[5] = '{size: 3, gap: 2, hold: 1, poke: 1, sv: 1, cr: '0, ci: '0,
              e0r: -111, e0i: -222, elr: 111, eli: 222};
    setc(5, 0, 1, 2); setc(5, 1, 10, 20); setc(5, 2, 100, 200);

    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 1; s <= 4; s++) begin
      sel = s;
      #1;
      check_zero("reset");
    end
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < 4; j++) begin
        cre[j] = int'($signed(vt[v].cr[j]));
        cim[j] = int'($signed(vt[v].ci[j]));
      end
      run(vt[v].size, vt[v].gap, vt[v].hold, vt[v].poke, vt[v].sv, -1);
      chk("vec_e0_re", got0r, vt[v].e0r);
      chk("vec_e0_im", got0i, vt[v].e0i);
      chk("vec_el_re", gotlr, vt[v].elr);
      chk("vec_el_im", gotli, vt[v].eli);
    end

    // Reset in the middle of BUILD, then a clean rebuild with new coefficients.
    for (int j = 0; j < 4; j++) begin cre[j] = -32768; cim[j] = 32767; end
    run(4, 0, 1'b0, 1'b0, 1'b0, 5);
    for (int j = 0; j < 4; j++) begin
      cre[j] = int'($signed(vt[2].cr[j]));
      cim[j] = int'($signed(vt[2].ci[j]));
    end
    run(4, 3, 1'b0, 1'b0, 1'b0, -1);
    chk("post_rst_e0_re", got0r, 4245);
    chk("post_rst_el_im", gotli, 1038);

    for (int r = 0; r < 100; r++) begin
      for (int j = 0; j < 4; j++) begin
        cre[j] = int'($signed(16'($urandom)));
        cim[j] = int'($signed(16'($urandom)));
      end
      run(3, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 4; j++) begin
        cre[j] = int'($signed(16'($urandom)));
        cim[j] = int'($signed(16'($urandom)));
      end
      run(4, 5, 1'($urandom_range(0, 1)), 1'b1, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
